// File: rtl/holly_bus_pkg.sv
// holly_bus_pkg: shared FSM states, address width and canonical HOLLY region constants
package holly_bus_pkg;
  localparam int HOLLY_ADDR_W = 29;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  localparam logic [HOLLY_ADDR_W-1:0] PVR_REG_BASE = 29'h005F7C00;
  localparam logic [HOLLY_ADDR_W-1:0] PVR_REG_MASK = 29'h1FFFFF00;
  localparam logic [HOLLY_ADDR_W-1:0] VRAM64_BASE  = 29'h04000000;
  localparam logic [HOLLY_ADDR_W-1:0] VRAM64_MASK  = 29'h1F800000;
  localparam logic [HOLLY_ADDR_W-1:0] SDRAM_BASE   = 29'h0C000000;
  localparam logic [HOLLY_ADDR_W-1:0] SDRAM_MASK   = 29'h1F000000;
  localparam logic [HOLLY_ADDR_W-1:0] TA_FIFO_BASE = 29'h10000000;
  localparam logic [HOLLY_ADDR_W-1:0] TA_FIFO_MASK = 29'h1F800000;
endpackage

// File: rtl/holly_bus_router_if.sv
// holly_bus_router_if: CPU request/response, per-target and error signals of the router
interface holly_bus_router_if
  import holly_bus_pkg::*;
#(
  parameter int N_TGT  = 4,
  parameter int DATA_W = 64
);
  logic [31:0]             cpu_req_addr;
  logic [DATA_W-1:0]       cpu_req_wdata;
  logic [DATA_W/8-1:0]     cpu_req_wmask;
  logic                    cpu_req_wen;
  logic                    cpu_req_valid;
  logic                    cpu_req_ready;
  logic [DATA_W-1:0]       cpu_resp_rdata;
  logic                    cpu_resp_valid;
  logic [N_TGT-1:0]        tgt_req_valid;
  logic [HOLLY_ADDR_W-1:0] tgt_req_addr;
  logic [DATA_W-1:0]       tgt_req_wdata;
  logic [DATA_W/8-1:0]     tgt_req_wmask;
  logic                    tgt_req_wen;
  logic [N_TGT-1:0]        tgt_resp_valid;
  logic [N_TGT*DATA_W-1:0] tgt_resp_rdata;
  logic                    err_unmapped;
  logic                    err_timeout;
  logic [15:0]             err_count;
  logic [HOLLY_ADDR_W-1:0] err_addr;
  modport slave (
    input  cpu_req_addr, cpu_req_wdata, cpu_req_wmask, cpu_req_wen, cpu_req_valid,
    input  tgt_resp_valid, tgt_resp_rdata,
    output cpu_req_ready, cpu_resp_rdata, cpu_resp_valid,
    output tgt_req_valid, tgt_req_addr, tgt_req_wdata, tgt_req_wmask, tgt_req_wen,
    output err_unmapped, err_timeout, err_count, err_addr
  );
  modport master (
    output cpu_req_addr, cpu_req_wdata, cpu_req_wmask, cpu_req_wen, cpu_req_valid,
    output tgt_resp_valid, tgt_resp_rdata,
    input  cpu_req_ready, cpu_resp_rdata, cpu_resp_valid,
    input  tgt_req_valid, tgt_req_addr, tgt_req_wdata, tgt_req_wmask, tgt_req_wen,
    input  err_unmapped, err_timeout, err_count, err_addr
  );
endinterface

// File: rtl/holly_region_match.sv
// holly_region_match: base/mask region decode, lowest matching index wins
module holly_region_match
  import holly_bus_pkg::*;
#(
  parameter int N_TGT = 4,
  parameter int IDX_W = 2
) (
  input  logic [HOLLY_ADDR_W-1:0]       addr,
  input  logic [N_TGT*HOLLY_ADDR_W-1:0] base,
  input  logic [N_TGT*HOLLY_ADDR_W-1:0] mask,
  output logic                          hit,
  output logic [IDX_W-1:0]              idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N_TGT; i++)
      if (!hit && (addr & mask[HOLLY_ADDR_W*i +: HOLLY_ADDR_W]) ==
          (base[HOLLY_ADDR_W*i +: HOLLY_ADDR_W] & mask[HOLLY_ADDR_W*i +: HOLLY_ADDR_W])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/holly_bus_router.sv
// holly_bus_router: single-outstanding SH4 data-bus router with timeout and unmapped error responses
module holly_bus_router
  import holly_bus_pkg::*;
#(
  parameter int N_TGT = 4,
  parameter int DATA_W = 64,
  parameter logic [N_TGT*HOLLY_ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_TGT*HOLLY_ADDR_W-1:0] REGION_MASK = '0,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = {DATA_W{1'b1}}
) (
  input logic clk,
  input logic rst,
  holly_bus_router_if.slave bus
);
  localparam int IDX_W = N_TGT > 1 ? $clog2(N_TGT) : 1;
  state_e state_q, state_d;
  logic [HOLLY_ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic wen_q, wen_d, eu_q, eu_d, et_q, et_d, hit;
  logic [IDX_W-1:0] sel_q, sel_d, idx;
  logic [15:0] cnt_q, cnt_d, err_count_q, err_count_d;
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.cpu_req_addr[31:HOLLY_ADDR_W];
  holly_region_match #(.N_TGT(N_TGT), .IDX_W(IDX_W)) u_match (
    .addr(bus.cpu_req_addr[HOLLY_ADDR_W-1:0]),
    .base(REGION_BASE),
    .mask(REGION_MASK),
    .hit (hit),
    .idx (idx)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wen_d = wen_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    eu_d = eu_q;
    et_d = et_q;
    err_count_d = err_count_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: if (bus.cpu_req_valid) begin
        addr_d = bus.cpu_req_addr[HOLLY_ADDR_W-1:0];
        wdata_d = bus.cpu_req_wdata;
        wmask_d = bus.cpu_req_wmask;
        wen_d = bus.cpu_req_wen;
        sel_d = idx;
        eu_d = !hit;
        et_d = 1'b0;
        rdata_d = hit ? rdata_q : UNMAPPED_DATA;
        state_d = hit ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        cnt_d = '0;
        state_d = S_WAIT;
      end
      // a target response wins over the timeout limit in the same cycle
      S_WAIT: if (bus.tgt_resp_valid[sel_q]) begin
        rdata_d = bus.tgt_resp_rdata[sel_q*DATA_W +: DATA_W];
        state_d = S_RESP;
      end else if (cnt_q == 16'(TIMEOUT - 1)) begin
        rdata_d = UNMAPPED_DATA;
        et_d = 1'b1;
        state_d = S_RESP;
      end else cnt_d = cnt_q + 16'd1;
      S_RESP: begin
        state_d = S_IDLE;
        err_addr_d = (eu_q || et_q) ? addr_q : err_addr_q;
        err_count_d = err_count_q + 16'((eu_q || et_q) && err_count_q != 16'hFFFF);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q <= 1'b0;
      sel_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      eu_q <= 1'b0;
      et_q <= 1'b0;
      err_count_q <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wen_q <= wen_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      eu_q <= eu_d;
      et_q <= et_d;
      err_count_q <= err_count_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign bus.cpu_req_ready = state_q == S_IDLE;
  assign bus.cpu_resp_valid = state_q == S_RESP;
  assign bus.cpu_resp_rdata = rdata_q;
  assign bus.tgt_req_valid = (state_q == S_ISSUE) ? N_TGT'(1) << sel_q : '0;
  assign bus.tgt_req_addr = addr_q;
  assign bus.tgt_req_wdata = wdata_q;
  assign bus.tgt_req_wmask = wmask_q;
  assign bus.tgt_req_wen = wen_q;
  assign bus.err_unmapped = (state_q == S_RESP) && eu_q;
  assign bus.err_timeout = (state_q == S_RESP) && et_q;
  assign bus.err_count = err_count_q;
  assign bus.err_addr = err_addr_q;
endmodule

// File: tb/tb_holly_bus_router.sv
// tb_holly_bus_router: randomized bench against a region-table and latency model of the router
module tb_holly_bus_router;
  localparam int TMO = 16;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] L0 = 64'hA5A5_0000_5A5A_1111;
  localparam logic [63:0] L2 = 64'hBAD0_BAD0_BAD0_BAD0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  logic [28:0] exp_eaddr = '0;
  logic [28:0] rb [3] = '{29'h005F7C00, 29'h04000000, 29'h0C000000};
  logic [28:0] rm [3] = '{29'h1FFFFF00, 29'h1F800000, 29'h1F000000};
  holly_bus_router_if #(.N_TGT(3), .DATA_W(64)) bus ();
  holly_bus_router_if #(.N_TGT(3), .DATA_W(64)) bus2 ();
  holly_bus_router #(
    .N_TGT(3), .DATA_W(64), .TIMEOUT(TMO), .UNMAPPED_DATA(ONES),
    .REGION_BASE({29'h0C000000, 29'h04000000, 29'h005F7C00}),
    .REGION_MASK({29'h1F000000, 29'h1F800000, 29'h1FFFFF00})
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  holly_bus_router #(
    .N_TGT(3), .DATA_W(64), .TIMEOUT(TMO), .UNMAPPED_DATA(ONES),
    .REGION_BASE({29'h00000000, 29'h04000000, 29'h005F7C00}),
    .REGION_MASK({29'h00000000, 29'h1F800000, 29'h1FFFFF00})
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a[28:0] & rm[i]) == (rb[i] & rm[i])) return i;
    return -1;
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] a, input logic w, input logic [63:0] wd,
                         input logic [7:0] wm, input int k, input logic [63:0] rd, input logic noise);
    int t, ec;
    logic unm, tmo;
    logic [6:0] cg, ce;
    logic [2:0] tv;
    logic [191:0] rv;
    t = model_sel(a);
    unm = t < 0;
    tmo = !unm && k == 0;
    ec = unm ? 1 : tmo ? 2 + TMO : 2 + k;
    @(negedge clk);
    total++;
    if (bus.cpu_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got=%b exp=1", nm, bus.cpu_req_ready);
    end
    bus.cpu_req_addr = a;
    bus.cpu_req_wen = w;
    bus.cpu_req_wdata = wd;
    bus.cpu_req_wmask = wm;
    bus.cpu_req_valid = 1'b1;
    for (int c = 1; c <= ec + 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr = $urandom;
        bus.cpu_req_wdata = {$urandom, $urandom};
        bus.cpu_req_wmask = 8'($urandom);
        bus.cpu_req_wen = 1'($urandom);
      end
      ce = {c > ec, c == ec, (!unm && c == 1) ? 3'b001 << t : 3'b000, c == ec && unm, c == ec && tmo};
      cg = {bus.cpu_req_ready, bus.cpu_resp_valid, bus.tgt_req_valid, bus.err_unmapped, bus.err_timeout};
      total++;
      if (cg !== ce) begin
        bad++;
        $display("FAIL %s ctrl c=%0d got=%b exp=%b (rdy,rv,tv[2:0],eu,et)", nm, c, cg, ce);
      end
      if (!unm) begin
        total++;
        if ({bus.tgt_req_addr, bus.tgt_req_wdata, bus.tgt_req_wmask, bus.tgt_req_wen} !== {a[28:0], wd, wm, w}) begin
          bad++;
          $display("FAIL %s payload c=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", nm, c, bus.tgt_req_addr,
                   bus.tgt_req_wdata, bus.tgt_req_wmask, bus.tgt_req_wen, a[28:0], wd, wm, w);
        end
      end
      if (c == ec) begin
        total++;
        if (bus.cpu_resp_rdata !== ((unm || tmo) ? ONES : rd)) begin
          bad++;
          $display("FAIL %s rdata got=%h exp=%h", nm, bus.cpu_resp_rdata, (unm || tmo) ? ONES : rd);
        end
        if (unm || tmo) begin
          exp_cnt++;
          exp_eaddr = a[28:0];
        end
      end
      if (c == ec + 1) begin
        total++;
        if ({bus.err_count, bus.err_addr} !== {16'(exp_cnt), exp_eaddr}) begin
          bad++;
          $display("FAIL %s err_cnt_addr got=%0d/%h exp=%0d/%h", nm, bus.err_count, bus.err_addr, exp_cnt, exp_eaddr);
        end
      end
      tv = noise ? 3'($urandom) : 3'b000;
      if (!unm) tv[t] = (noise && (c == 1 || c >= ec) && tv[t]) || (k > 0 && c == 1 + k) || (tmo && c == ec + 2);
      rv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (!unm && k > 0 && c == 1 + k) rv[t*64 +: 64] = rd;
      bus.tgt_resp_valid = tv;
      bus.tgt_resp_rdata = rv;
    end
    bus.tgt_resp_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.cpu_req_ready, bus.cpu_resp_valid, bus.tgt_req_valid, bus.err_unmapped, bus.err_timeout} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=1000000", {bus.cpu_req_ready, bus.cpu_resp_valid,
               bus.tgt_req_valid, bus.err_unmapped, bus.err_timeout});
    end
    total++;
    if ({bus.cpu_resp_rdata, bus.tgt_req_addr, bus.tgt_req_wdata, bus.tgt_req_wmask, bus.tgt_req_wen,
         bus.err_count, bus.err_addr} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%b/%0d/%h exp=all zero", bus.cpu_resp_rdata, bus.tgt_req_addr,
               bus.tgt_req_wdata, bus.tgt_req_wmask, bus.tgt_req_wen, bus.err_count, bus.err_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    run_txn("read_pvr", 32'h005F7C04, 1'b0, 64'h0, 8'hFF, 2, 64'h1234, 1'b0);
  endtask

  task automatic test_write();
    run_txn("write_sdram", 32'h0C000010, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1, 64'h77, 1'b0);
  endtask

  task automatic test_unmapped();
    run_txn("unmapped", 32'h1F000000, 1'b0, 64'h0, 8'hFF, 1, 64'h0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 32'h04000100, 1'b0, 64'h0, 8'hFF, 0, 64'h0, 1'b0);
  endtask

  task automatic prio_case(input string nm, input logic [31:0] a, input logic [2:0] etv,
                           input logic [2:0] v2, input logic [2:0] v3, input int ec, input logic [63:0] erd);
    @(negedge clk);
    bus2.cpu_req_addr = a;
    bus2.cpu_req_wen = 1'b0;
    bus2.cpu_req_valid = 1'b1;
    for (int c = 1; c <= ec + 1; c++) begin
      @(negedge clk);
      bus2.cpu_req_valid = 1'b0;
      total++;
      if ({bus2.tgt_req_valid, bus2.cpu_resp_valid, bus2.err_unmapped} !== {c == 1 ? etv : 3'b000, c == ec, 1'b0}) begin
        bad++;
        $display("FAIL %s ctrl c=%0d got=%b exp=%b", nm, c, {bus2.tgt_req_valid, bus2.cpu_resp_valid,
                 bus2.err_unmapped}, {c == 1 ? etv : 3'b000, c == ec, 1'b0});
      end
      if (c == ec) begin
        total++;
        if (bus2.cpu_resp_rdata !== erd) begin
          bad++;
          $display("FAIL %s rdata got=%h exp=%h", nm, bus2.cpu_resp_rdata, erd);
        end
      end
      bus2.tgt_resp_valid = (c == 2) ? v2 : (c == 3) ? v3 : 3'b000;
      bus2.tgt_resp_rdata = {L2, 64'h0, L0};
    end
    bus2.tgt_resp_valid = '0;
  endtask

  task automatic test_priority();
    prio_case("prio_pvr", 32'h005F7C00, 3'b001, 3'b100, 3'b101, 4, L0);
    prio_case("catch_all", 32'h1F000000, 3'b100, 3'b100, 3'b000, 3, L2);
  endtask

  task automatic test_random();
    int s;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 3);
      a = (s == 3) ? $urandom : {3'($urandom), rb[s] | (29'($urandom) & ~rm[s])};
      run_txn("random", a, 1'($urandom), {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 4),
              {$urandom, $urandom}, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cpu_req_addr = 32'h0C000020;
    bus.cpu_req_wen = 1'b0;
    bus.cpu_req_valid = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_eaddr = '0;
    total++;
    if ({bus.cpu_req_ready, bus.cpu_resp_valid, bus.err_count, bus.err_addr} !== {2'b10, 16'(exp_cnt), exp_eaddr}) begin
      bad++;
      $display("FAIL reset_mid_state got=%b/%b/%0d/%h exp=1/0/0/0", bus.cpu_req_ready, bus.cpu_resp_valid,
               bus.err_count, bus.err_addr);
    end
    for (int c = 0; c < 4; c++) begin
      bus.tgt_resp_valid = 3'b100;
      bus.tgt_resp_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      total++;
      if ({bus.cpu_req_ready, bus.cpu_resp_valid, bus.tgt_req_valid} !== 5'b10000) begin
        bad++;
        $display("FAIL reset_mid_late c=%0d got=%b exp=10000", c, {bus.cpu_req_ready, bus.cpu_resp_valid, bus.tgt_req_valid});
      end
    end
    bus.tgt_resp_valid = '0;
  endtask

  initial begin
    bus.cpu_req_addr = '0;
    bus.cpu_req_wdata = '0;
    bus.cpu_req_wmask = '0;
    bus.cpu_req_wen = 1'b0;
    bus.cpu_req_valid = 1'b0;
    bus.tgt_resp_valid = '0;
    bus.tgt_resp_rdata = '0;
    bus2.cpu_req_addr = '0;
    bus2.cpu_req_wdata = '0;
    bus2.cpu_req_wmask = '0;
    bus2.cpu_req_wen = 1'b0;
    bus2.cpu_req_valid = 1'b0;
    bus2.tgt_resp_valid = '0;
    bus2.tgt_resp_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_priority();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
